// File: rtl/cam_pkg.sv
// Shared CAM access definitions: sequencer states, opcodes, default word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cam_pkg;

  localparam int CAM_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SETUP = 3'd1,
    ST_WR_PULSE = 3'd2,
    ST_WR_HOLD  = 3'd3,
    ST_PRECH    = 3'd4,
    ST_EVAL     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Phase lengths live in 3-bit counters; a zero length would never expire, so it runs as one cycle.
  function automatic logic [2:0] phase_len(input int cyc);
    logic [2:0] len;
    if (cyc <= 0) len = 3'd1;
    else          len = cyc[2:0];
    return len;
  endfunction

endpackage

// File: rtl/wl_decoder2x4.sv
// Row decoder: 2-bit row address plus enable to one-hot wordline vector.
// Latency: combinational.
// Backpressure: none.
module wl_decoder2x4 (
  input  logic [1:0] addr_i,
  input  logic       en_i,
  output logic [3:0] wl_o
);

  // Exactly one wordline when enabled, none otherwise.
  always_comb begin
    wl_o = 4'b0000;
    if (en_i) wl_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/cam_access_ctrl.sv
// CAM access sequencer: write pulse timing, matchline precharge/evaluate, row-valid tracking.
// Latency: write 3+PW_CYC, search 1+PRE_CYC+EVAL_CYC, invalidate/reserved 1 cycle to ACK.
// Backpressure: REQ is sampled only in IDLE; requests while BUSY are dropped.
module cam_access_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH    = CAM_WIDTH,
  parameter int PW_CYC   = 2,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ,
  input  logic [1:0]       OP,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] DATA,
  output logic             ACK,
  output logic             BUSY,
  output logic [3:0]       WL,
  output logic [WIDTH-1:0] BL_DATA,
  output logic             WR_EN,
  output logic             PRE,
  output logic             SL_EN,
  output logic [WIDTH-1:0] SL_DATA,
  input  logic [3:0]       ML,
  output logic [3:0]       MATCH_VEC,
  output logic             HIT,
  output logic [1:0]       HIT_ADDR
);

  localparam logic [2:0] PW_LEN   = phase_len(PW_CYC);
  localparam logic [2:0] PRE_LEN  = phase_len(PRE_CYC);
  localparam logic [2:0] EVAL_LEN = phase_len(EVAL_CYC);

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [1:0]       addr_q;
  logic [WIDTH-1:0] key_q;
  logic [3:0]       valid_q;
  logic             ack_q;
  logic             busy_q;
  logic             wl_en_q;
  logic [WIDTH-1:0] bl_q;
  logic             wr_en_q;
  logic             pre_q;
  logic             sl_en_q;
  logic [WIDTH-1:0] sl_q;
  logic [3:0]       match_vec_q;
  logic             hit_q;
  logic [1:0]       hit_addr_q;

  logic [3:0]       match_d;
  logic             hit_d;
  logic [1:0]       hit_addr_d;

  // Mask raw matchlines with row-valid bits and pick the lowest matching row.
  always_comb begin
    match_d    = ML & valid_q;
    hit_d      = |match_d;
    hit_addr_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (match_d[i]) hit_addr_d = 2'(i);
    end
  end

  // Sequencer: state, phase counter and every array-facing output registered together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= 2'd0;
      key_q       <= '0;
      valid_q     <= 4'b0000;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      wl_en_q     <= 1'b0;
      bl_q        <= '0;
      wr_en_q     <= 1'b0;
      pre_q       <= 1'b0;
      sl_en_q     <= 1'b0;
      sl_q        <= '0;
      match_vec_q <= 4'b0000;
      hit_q       <= 1'b0;
      hit_addr_q  <= 2'd0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            addr_q <= ADDR;
            key_q  <= DATA;
            busy_q <= 1'b1;
            case (OP)
              OP_WRITE: begin
                state_q <= ST_WR_SETUP;
                wl_en_q <= 1'b1;
                bl_q    <= DATA;
              end
              OP_SEARCH: begin
                state_q <= ST_PRECH;
                pre_q   <= 1'b1;
                cnt_q   <= PRE_LEN;
              end
              OP_INVAL: begin
                state_q       <= ST_DONE;
                ack_q         <= 1'b1;
                valid_q[ADDR] <= 1'b0;
              end
              default: begin
                // Reserved opcode: complete with no side effect.
                state_q <= ST_DONE;
                ack_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_WR_SETUP: begin
          state_q <= ST_WR_PULSE;
          wr_en_q <= 1'b1;
          cnt_q   <= PW_LEN;
        end
        ST_WR_PULSE: begin
          if (cnt_q == 3'd1) begin
            state_q <= ST_WR_HOLD;
            wr_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_WR_HOLD: begin
          state_q         <= ST_DONE;
          wl_en_q         <= 1'b0;
          bl_q            <= '0;
          valid_q[addr_q] <= 1'b1;
          ack_q           <= 1'b1;
        end
        ST_PRECH: begin
          if (cnt_q == 3'd1) begin
            state_q <= ST_EVAL;
            pre_q   <= 1'b0;
            sl_en_q <= 1'b1;
            sl_q    <= key_q;
            cnt_q   <= EVAL_LEN;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_EVAL: begin
          if (cnt_q == 3'd1) begin
            // Matchlines are captured on the final evaluate edge only.
            state_q     <= ST_DONE;
            sl_en_q     <= 1'b0;
            sl_q        <= '0;
            ack_q       <= 1'b1;
            match_vec_q <= match_d;
            hit_q       <= hit_d;
            hit_addr_q  <= hit_addr_d;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  wl_decoder2x4 u_wl_dec (
    .addr_i (addr_q),
    .en_i   (wl_en_q),
    .wl_o   (WL)
  );

  assign ACK       = ack_q;
  assign BUSY      = busy_q;
  assign BL_DATA   = bl_q;
  assign WR_EN     = wr_en_q;
  assign PRE       = pre_q;
  assign SL_EN     = sl_en_q;
  assign SL_DATA   = sl_q;
  assign MATCH_VEC = match_vec_q;
  assign HIT       = hit_q;
  assign HIT_ADDR  = hit_addr_q;

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Bench for cam_access_ctrl: directed table, held-REQ schedule, random ops vs a row-valid model, mid-write reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_cam_access_ctrl;

  localparam int W  = 8;
  localparam int PW = 2;
  localparam int PR = 1;
  localparam int EV = 2;

  localparam logic [1:0] WR = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] IV = 2'b10;
  localparam logic [1:0] RS = 2'b11;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         REQ = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [1:0]   ADDR = 2'b00;
  logic [W-1:0] DATA = '0;
  logic [3:0]   ML = 4'b0000;
  logic         ACK, BUSY, WR_EN, PRE, SL_EN, HIT;
  logic [3:0]   WL, MATCH_VEC;
  logic [W-1:0] BL_DATA, SL_DATA;
  logic [1:0]   HIT_ADDR;

  cam_access_ctrl #(.WIDTH(W), .PW_CYC(PW), .PRE_CYC(PR), .EVAL_CYC(EV)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP(OP), .ADDR(ADDR), .DATA(DATA),
    .ACK(ACK), .BUSY(BUSY), .WL(WL), .BL_DATA(BL_DATA), .WR_EN(WR_EN),
    .PRE(PRE), .SL_EN(SL_EN), .SL_DATA(SL_DATA), .ML(ML),
    .MATCH_VEC(MATCH_VEC), .HIT(HIT), .HIT_ADDR(HIT_ADDR)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nfail = 0;

  // Reference state: which rows hold data, and the last search result.
  bit [3:0] m_valid = 4'b0000;
  bit [3:0] m_mv = 4'b0000;
  bit       m_hit = 1'b0;
  bit [1:0] m_ha = 2'd0;

  typedef struct {
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] data;
    logic [3:0] ml;
    logic [3:0] mv;
    logic       hit;
    logic [1:0] ha;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat(input logic [1:0] op);
    if (op == WR) return 3 + PW;
    if (op == SR) return 1 + PR + EV;
    return 1;
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] ml);
    case (op)
      WR: m_valid[addr] = 1'b1;
      IV: m_valid[addr] = 1'b0;
      SR: begin
        m_mv  = ml & m_valid;
        m_hit = (m_mv != 4'b0000);
        m_ha  = 2'd0;
        for (int i = 3; i >= 0; i--) if (m_mv[i]) m_ha = 2'(i);
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] all_outs();
    return {ACK, BUSY, WL, BL_DATA, WR_EN, PRE, SL_EN, SL_DATA, MATCH_VEC, HIT, HIT_ADDR};
  endfunction

  // One operation from an idle DUT: per-cycle strobe checks, then the result against the model.
  task automatic do_op(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data,
                       input logic [3:0] ml, input string tag);
    int L;
    logic [3:0] oh;
    L  = lat(op);
    oh = 4'b0001 << addr;
    @(negedge CLK);
    REQ = 1'b1; OP = op; ADDR = addr; DATA = data; ML = ml;
    @(posedge CLK);
    #1;
    REQ = 1'b0; OP = 2'($urandom); ADDR = 2'($urandom); DATA = 8'($urandom);
    for (int c = 1; c <= L + 1; c++) begin
      logic ack_e, busy_e, wl_on, wr_e, pre_e, sl_e;
      @(negedge CLK);
      ack_e  = (c == L);
      busy_e = (c <= L);
      wl_on = 1'b0; wr_e = 1'b0; pre_e = 1'b0; sl_e = 1'b0;
      if (op == WR) begin
        wl_on = (c <= 2 + PW);
        wr_e  = (c >= 2) && (c <= 1 + PW);
      end
      if (op == SR) begin
        pre_e = (c <= PR);
        sl_e  = (c > PR) && (c <= PR + EV);
      end
      chk($sformatf("%s ctl c%0d {ack,busy,wr_en,pre,sl_en,wl}", tag, c),
          {ACK, BUSY, WR_EN, PRE, SL_EN, WL},
          {ack_e, busy_e, wr_e, pre_e, sl_e, (wl_on ? oh : 4'b0000)});
      if (wl_on) chk($sformatf("%s bl_data c%0d", tag, c), BL_DATA, data);
      if (sl_e)  chk($sformatf("%s sl_data c%0d", tag, c), SL_DATA, data);
    end
    model_apply(op, addr, ml);
    chk($sformatf("%s result {mv,hit,ha}", tag), {MATCH_VEC, HIT, HIT_ADDR}, {m_mv, m_hit, m_ha});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] hops[6];
    logic [1:0] haddr[6];
    int acc[7];
    bit exp_ack[0:127];
    bit exp_busy[0:127];
    int T, k;

    // Reset state: every output low while reset is held.
    repeat (3) begin
      @(negedge CLK);
      chk("reset outputs", all_outs(), 32'd0);
    end
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed table: {op, addr, data, ml} -> {match_vec, hit, hit_addr} afterwards.
    tbl[0]  = '{WR, 2'd1, 8'h3C, 4'h0, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{WR, 2'd3, 8'hC3, 4'h0, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{SR, 2'd0, 8'h11, 4'hF, 4'b1010, 1'b1, 2'd1};
    tbl[3]  = '{IV, 2'd1, 8'h00, 4'hF, 4'b1010, 1'b1, 2'd1};
    tbl[4]  = '{SR, 2'd0, 8'h22, 4'hF, 4'b1000, 1'b1, 2'd3};
    tbl[5]  = '{SR, 2'd0, 8'h33, 4'h0, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{WR, 2'd2, 8'hA5, 4'h0, 4'b0000, 1'b0, 2'd0};
    tbl[7]  = '{SR, 2'd1, 8'hA5, 4'h4, 4'b0100, 1'b1, 2'd2};
    tbl[8]  = '{RS, 2'd2, 8'hFF, 4'hF, 4'b0100, 1'b1, 2'd2};
    tbl[9]  = '{SR, 2'd0, 8'h44, 4'hF, 4'b1100, 1'b1, 2'd2};
    tbl[10] = '{WR, 2'd2, 8'h5A, 4'hF, 4'b1100, 1'b1, 2'd2};
    tbl[11] = '{IV, 2'd0, 8'h00, 4'hF, 4'b1100, 1'b1, 2'd2};
    tbl[12] = '{SR, 2'd3, 8'h5A, 4'h5, 4'b0100, 1'b1, 2'd2};
    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].ml, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d expected {mv,hit,ha}", i), {MATCH_VEC, HIT, HIT_ADDR},
          {tbl[i].mv, tbl[i].hit, tbl[i].ha});
    end

    // REQ held high through a run of mixed ops: accepted only in IDLE, one ACK each.
    hops  = '{WR, SR, IV, WR, SR, IV};
    haddr = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int n = 0; n < 128; n++) begin
      exp_ack[n] = 1'b0;
      exp_busy[n] = 1'b0;
    end
    acc[0] = 0;
    for (int i = 0; i < 6; i++) begin
      acc[i+1] = acc[i] + lat(hops[i]) + 1;
      for (int c = acc[i] + 1; c <= acc[i] + lat(hops[i]); c++) exp_busy[c] = 1'b1;
      exp_ack[acc[i] + lat(hops[i])] = 1'b1;
    end
    T = acc[6];
    @(negedge CLK);
    ML = 4'hF;
    REQ = 1'b1; OP = hops[0]; ADDR = haddr[0]; DATA = 8'h66;
    k = 1;
    for (int n = 1; n <= T; n++) begin
      @(negedge CLK);
      chk($sformatf("held-req c%0d {ack,busy}", n), {ACK, BUSY}, {exp_ack[n], exp_busy[n]});
      if (n == T) begin
        REQ = 1'b0;
      end else if (k < 6 && n == acc[k]) begin
        OP = hops[k]; ADDR = haddr[k]; DATA = 8'h66;
        k++;
      end else begin
        OP = 2'($urandom); ADDR = 2'($urandom); DATA = 8'($urandom);
      end
    end
    for (int i = 0; i < 6; i++) model_apply(hops[i], haddr[i], 4'hF);
    @(negedge CLK);
    chk("held-req result {mv,hit,ha,busy}", {MATCH_VEC, HIT, HIT_ADDR, BUSY}, {m_mv, m_hit, m_ha, 1'b0});

    // Random operations against the row-valid model.
    for (int i = 0; i < 200; i++) begin
      do_op(2'($urandom_range(0, 3)), 2'($urandom), 8'($urandom), 4'($urandom), $sformatf("rnd%0d", i));
    end

    // Make a hit visible, then reset in the middle of a write pulse.
    do_op(WR, 2'd2, 8'h99, 4'h0, "pre-rst write");
    do_op(SR, 2'd0, 8'h99, 4'hF, "pre-rst search");
    @(negedge CLK);
    REQ = 1'b1; OP = WR; ADDR = 2'd1; DATA = 8'h77;
    @(posedge CLK);
    #1;
    REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid-write wr_en before reset", WR_EN, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async reset {wr_en,wl,busy,ack}", {WR_EN, WL, BUSY, ACK}, 7'd0);
    chk("async reset all outputs", all_outs(), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      chk("held reset all outputs", all_outs(), 32'd0);
    end
    RST_N = 1'b1;
    m_valid = 4'b0000; m_mv = 4'b0000; m_hit = 1'b0; m_ha = 2'd0;
    do_op(SR, 2'd0, 8'h77, 4'hF, "post-rst search");
    do_op(WR, 2'd3, 8'h12, 4'h0, "post-rst write");
    do_op(SR, 2'd0, 8'h12, 4'hF, "post-rst search2");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
